// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module : vga_pkg
//  Brief  : Shared timing sets, pipeline control record and pixel-unpack helper
//           for the scaled VGA scan-out engine.
//  Rev    : 1.0  initial release
// ============================================================================
package vga_pkg;

  // 800x600 @ 60 Hz (40 MHz pixel rate)
  localparam int SVGA_H_ACTIVE = 800;
  localparam int SVGA_H_FP     = 40;
  localparam int SVGA_H_SYNC   = 128;
  localparam int SVGA_H_BP     = 88;
  localparam int SVGA_V_ACTIVE = 600;
  localparam int SVGA_V_FP     = 1;
  localparam int SVGA_V_SYNC   = 4;
  localparam int SVGA_V_BP     = 23;
  localparam int SVGA_H_TOTAL  = SVGA_H_ACTIVE + SVGA_H_FP + SVGA_H_SYNC + SVGA_H_BP;
  localparam int SVGA_V_TOTAL  = SVGA_V_ACTIVE + SVGA_V_FP + SVGA_V_SYNC + SVGA_V_BP;

  // 640x480 @ 60 Hz (25.175 MHz pixel rate)
  localparam int VGA_H_ACTIVE  = 640;
  localparam int VGA_H_FP      = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BP      = 48;
  localparam int VGA_V_ACTIVE  = 480;
  localparam int VGA_V_FP      = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BP      = 33;
  localparam int VGA_H_TOTAL   = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL   = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Timing/control bits that travel alongside the pixel through the pipeline
  typedef struct packed {
    logic de;
    logic hsync;
    logic vsync;
    logic vblank;
    logic fstart;
  } vid_ctl_t;

  // Extract a channel of 'width' bits starting at bit 'lsb' of a packed pixel word
  function automatic int unsigned pix_field(input int unsigned word, input int lsb, input int width);
    return (word >> lsb) & ((32'd1 << width) - 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
//  Module : vga_axis_counter
//  Brief  : One timing axis (horizontal or vertical): position counter with
//           terminal-count, active-region and sync-level decodes.
//  Rev    : 1.0  initial release
// ============================================================================
module vga_axis_counter #(
  parameter int   ACTIVE = 800,
  parameter int   FP     = 40,
  parameter int   SYNC   = 128,
  parameter int   BP     = 88,
  parameter logic POL    = 1'b0,
  parameter int   CNT_W  = $clog2(ACTIVE + FP + SYNC + BP)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic             active,
  output logic             sync
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;

  assign wrap   = (cnt == CNT_W'(TOTAL - 1));
  assign active = (cnt < CNT_W'(ACTIVE));
  assign sync   = ((cnt >= CNT_W'(ACTIVE + FP)) && (cnt < CNT_W'(ACTIVE + FP + SYNC))) ? POL : ~POL;

  // Position advances on each enable and returns to 0 after the last count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_scaled_scanout.sv
`default_nettype none
// ============================================================================
//  Module : vga_scaled_scanout
//  Brief  : VGA timing plus down-scaled framebuffer fetch. Each stored pixel is
//           replicated H_SCALE x V_SCALE on screen; 3-stage pixel pipeline
//           (address -> data capture -> RGB/sync outputs).
//  Rev    : 1.0  initial release
// ============================================================================
module vga_scaled_scanout
  import vga_pkg::*;
#(
  parameter int   CLK_DIV  = 6,
  parameter int   H_ACTIVE = SVGA_H_ACTIVE,
  parameter int   H_FP     = SVGA_H_FP,
  parameter int   H_SYNC   = SVGA_H_SYNC,
  parameter int   H_BP     = SVGA_H_BP,
  parameter int   V_ACTIVE = SVGA_V_ACTIVE,
  parameter int   V_FP     = SVGA_V_FP,
  parameter int   V_SYNC   = SVGA_V_SYNC,
  parameter int   V_BP     = SVGA_V_BP,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   H_SCALE  = 4,
  parameter int   V_SCALE  = 4,
  parameter int   ADDR_W   = 15,
  parameter int   R_W      = 3,
  parameter int   G_W      = 3,
  parameter int   B_W      = 2,
  localparam int  PIX_W    = R_W + G_W + B_W
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] address,
  input  logic [PIX_W-1:0]  data,
  input  logic              blank_req,
  output logic [R_W-1:0]    R,
  output logic [G_W-1:0]    G,
  output logic [B_W-1:0]    B,
  output logic              hSync,
  output logic              vSync,
  output logic              de,
  output logic              frame_start,
  output logic              vblank
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HC_W    = $clog2(H_TOTAL);
  localparam int VC_W    = $clog2(V_TOTAL);
  localparam int FB_W    = H_ACTIVE / H_SCALE;
  localparam int FB_H    = V_ACTIVE / V_SCALE;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HS_W    = (H_SCALE > 1) ? $clog2(H_SCALE) : 1;
  localparam int VS_W    = (V_SCALE > 1) ? $clog2(V_SCALE) : 1;
  localparam vid_ctl_t CTL_IDLE = '{de: 1'b0, hsync: ~HS_POL, vsync: ~VS_POL, vblank: 1'b0, fstart: 1'b0};

  // Reject parameter sets the address generator cannot represent
  if (CLK_DIV < 1) begin : g_chk_div
    $error("CLK_DIV must be at least 1");
  end
  if ((H_ACTIVE % H_SCALE) != 0) begin : g_chk_hscale
    $error("H_SCALE must divide H_ACTIVE");
  end
  if ((V_ACTIVE % V_SCALE) != 0) begin : g_chk_vscale
    $error("V_SCALE must divide V_ACTIVE");
  end
  if ((longint'(FB_W) * longint'(FB_H)) > (longint'(1) << ADDR_W)) begin : g_chk_addr
    $error("framebuffer does not fit in ADDR_W address bits");
  end

  logic [DIV_W-1:0]  div_cnt;
  logic              pix_en;
  logic [HC_W-1:0]   h_cnt;
  logic [VC_W-1:0]   v_cnt;
  logic              h_wrap, v_wrap, h_active, v_active, h_sync, v_sync;
  logic [HS_W-1:0]   hs_cnt;
  logic [VS_W-1:0]   vs_cnt;
  logic [ADDR_W-1:0] fb_x, line_base;
  logic [PIX_W-1:0]  pix_s1;
  vid_ctl_t          ctl_now, ctl_s0, ctl_s1;

  assign pix_en = (div_cnt == DIV_W'(CLK_DIV - 1));

  // Pixel-tick divider: one pix_en every CLK_DIV clocks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= pix_en ? '0 : div_cnt + 1'b1;
    end
  end

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL), .CNT_W(HC_W)
  ) u_h_axis (
    .clk(clk), .rst_n(rst_n), .en(pix_en),
    .cnt(h_cnt), .wrap(h_wrap), .active(h_active), .sync(h_sync)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL), .CNT_W(VC_W)
  ) u_v_axis (
    .clk(clk), .rst_n(rst_n), .en(pix_en & h_wrap),
    .cnt(v_cnt), .wrap(v_wrap), .active(v_active), .sync(v_sync)
  );

  // Read address for the current position; scale counters step toward the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      address   <= '0;
      fb_x      <= '0;
      line_base <= '0;
      hs_cnt    <= '0;
      vs_cnt    <= '0;
    end else if (pix_en) begin
      if (h_active && v_active) begin
        address <= line_base + fb_x;
      end
      if (h_wrap) begin
        hs_cnt <= '0;
        fb_x   <= '0;
        if (v_wrap) begin
          vs_cnt    <= '0;
          line_base <= '0;
        end else if (v_active) begin
          if (vs_cnt == VS_W'(V_SCALE - 1)) begin
            vs_cnt    <= '0;
            line_base <= line_base + ADDR_W'(FB_W);
          end else begin
            vs_cnt <= vs_cnt + 1'b1;
          end
        end
      end else if (h_active) begin
        if (hs_cnt == HS_W'(H_SCALE - 1)) begin
          hs_cnt <= '0;
          fb_x   <= fb_x + 1'b1;
        end else begin
          hs_cnt <= hs_cnt + 1'b1;
        end
      end
    end
  end

  assign ctl_now = '{de:     h_active & v_active,
                     hsync:  h_sync,
                     vsync:  v_sync,
                     vblank: ~v_active,
                     fstart: (h_cnt == '0) && (v_cnt == '0)};

  // Delay timing by two ticks and capture RAM data one tick after its address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_s0 <= CTL_IDLE;
      ctl_s1 <= CTL_IDLE;
      pix_s1 <= '0;
    end else if (pix_en) begin
      ctl_s0 <= ctl_now;
      ctl_s1 <= ctl_s0;
      pix_s1 <= data;
    end
  end

  // Output stage: colour gated by de and blank_req; frame_start lasts one clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      R           <= '0;
      G           <= '0;
      B           <= '0;
      de          <= 1'b0;
      hSync       <= ~HS_POL;
      vSync       <= ~VS_POL;
      vblank      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pix_en) begin
        de          <= ctl_s1.de;
        hSync       <= ctl_s1.hsync;
        vSync       <= ctl_s1.vsync;
        vblank      <= ctl_s1.vblank;
        frame_start <= ctl_s1.fstart;
        if (ctl_s1.de && !blank_req) begin
          R <= R_W'(pix_field(32'(pix_s1), G_W + B_W, R_W));
          G <= G_W'(pix_field(32'(pix_s1), B_W, G_W));
          B <= B_W'(pix_field(32'(pix_s1), 0, B_W));
        end else begin
          R <= '0;
          G <= '0;
          B <= '0;
        end
      end
    end
  end

endmodule
`default_nettype wire
